// File: rtl/grant_bus_mux.sv
// rtl/grant_bus_mux.sv - burst-locked 3:1 grant mux with registered output stage; optional grant check under GRANT_BUS_MUX_GNT_CHECK_EN
module grant_bus_mux #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gnt_0,
  input  logic             gnt_1,
  input  logic             gnt_2,
  input  logic             valid_0,
  input  logic             valid_1,
  input  logic             valid_2,
  input  logic [WIDTH-1:0] data_0,
  input  logic [WIDTH-1:0] data_1,
  input  logic [WIDTH-1:0] data_2,
  output logic             ready_0,
  output logic             ready_1,
  output logic             ready_2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic             busy,
  output logic             gnt_err
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_src_q, out_src_d;

  logic [2:0]       gnt_vec;
  logic             owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic             owner_gnt;
  logic [2:0]       owner_onehot;
  logic             ready_owner;
  logic             xfer;
  logic             unload;

  assign gnt_vec = {gnt_2, gnt_1, gnt_0};

  // Select the locked owner's valid, data and grant, plus its one-hot position
  always_comb begin
    owner_valid  = 1'b0;
    owner_data   = '0;
    owner_gnt    = 1'b0;
    owner_onehot = 3'b000;
    case (owner_q)
      2'd0: begin
        owner_valid  = valid_0;
        owner_data   = data_0;
        owner_gnt    = gnt_0;
        owner_onehot = 3'b001;
      end
      2'd1: begin
        owner_valid  = valid_1;
        owner_data   = data_1;
        owner_gnt    = gnt_1;
        owner_onehot = 3'b010;
      end
      2'd2: begin
        owner_valid  = valid_2;
        owner_data   = data_2;
        owner_gnt    = gnt_2;
        owner_onehot = 3'b100;
      end
      default: begin
        owner_valid  = 1'b0;
        owner_data   = '0;
        owner_gnt    = 1'b0;
        owner_onehot = 3'b000;
      end
    endcase
  end

  // The owner may push whenever the output register is empty or being drained this cycle
  assign ready_owner = (state_q == S_LOCK) && (!out_valid_q || out_ready);
  assign xfer        = ready_owner && owner_valid;
  assign unload      = out_valid_q && out_ready;

  assign ready_0 = ready_owner && owner_onehot[0];
  assign ready_1 = ready_owner && owner_onehot[1];
  assign ready_2 = ready_owner && owner_onehot[2];

  // Output register next state: a load wins over an unload so the stage can stream
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_data;
      out_src_d   = owner_q;
    end else if (unload) begin
      out_valid_d = 1'b0;
    end
  end

  // FSM next state: lock on a grant, count beats, drain the output register before re-arbitrating
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt_vec) begin
          if (gnt_0) begin
            owner_d = 2'd0;
          end else if (gnt_1) begin
            owner_d = 2'd1;
          end else begin
            owner_d = 2'd2;
          end
          cnt_d   = '0;
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = out_valid_d ? S_DRAIN : S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (unload) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; out_src resets to 3 so "no owner yet" is visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 2'b11;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q != S_IDLE);

`ifdef GRANT_BUS_MUX_GNT_CHECK_EN
  logic gnt_err_q;
  logic multi_gnt;
  logic stray_gnt;
  logic err_set;

  assign multi_gnt = (gnt_vec & (gnt_vec - 3'd1)) != 3'b000;
  assign stray_gnt = !owner_gnt && ((gnt_vec & ~owner_onehot) != 3'b000);
  assign err_set   = ((state_q == S_IDLE) && multi_gnt) ||
                     ((state_q == S_LOCK) && stray_gnt);

  // Sticky flag for a non-one-hot grant in IDLE or the arbiter moving on mid-burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_err_q <= 1'b0;
    end else if (err_set) begin
      gnt_err_q <= 1'b1;
    end
  end

  assign gnt_err = gnt_err_q;
`else
  assign gnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_grant_bus_mux.sv
// tb/tb_grant_bus_mux.sv - randomized self-checking bench for grant_bus_mux
module tb_grant_bus_mux;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         gnt_0, gnt_1, gnt_2;
  logic         valid_0, valid_1, valid_2;
  logic [W-1:0] data_0, data_1, data_2;
  logic         out_ready;

  logic         ready_0, ready_1, ready_2, out_valid, busy, gnt_err;
  logic [W-1:0] out_data;
  logic [1:0]   out_src;
  logic         b1_ready_0, b1_ready_1, b1_ready_2, b1_out_valid, b1_busy, b1_gnt_err;
  logic [W-1:0] b1_out_data;
  logic [1:0]   b1_out_src;

  grant_bus_mux #(.WIDTH(W), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy), .gnt_err(gnt_err)
  );

  grant_bus_mux #(.WIDTH(W), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .valid_0(valid_0), .valid_1(valid_1), .valid_2(valid_2),
    .data_0(data_0), .data_1(data_1), .data_2(data_2),
    .ready_0(b1_ready_0), .ready_1(b1_ready_1), .ready_2(b1_ready_2),
    .out_valid(b1_out_valid), .out_data(b1_out_data), .out_src(b1_out_src),
    .out_ready(out_ready), .busy(b1_busy), .gnt_err(b1_gnt_err)
  );

  int checks = 0;
  int failures = 0;
  bit exp_err;

  // Source model: requester k presents src_base[k] + src_idx[k], advancing on each handshake
  logic [7:0]   src_base [3];
  int           src_idx [3];
  int           vprob [3];
  int           rprob;
  bit           use_pat;
  logic [31:0]  rdy_pat;
  int           pulse_cyc [3];
  int           cur_owner;

  logic [7:0]   obs_data [$];
  logic [1:0]   obs_src [$];
  int           obs_cyc [$];
  int           bad_ready, hold_bad, owner_ready_cnt;

  function automatic logic rdy_bit(input int i);
    if (use_pat) return (i < 32) ? rdy_pat[i] : 1'b1;
    return (int'($urandom_range(99)) < rprob);
  endfunction

  task automatic drive_data();
    data_0 = 8'(src_base[0] + 8'(src_idx[0]));
    data_1 = 8'(src_base[1] + 8'(src_idx[1]));
    data_2 = 8'(src_base[2] + 8'(src_idx[2]));
  endtask

  task automatic drive_valids();
    valid_0 = (int'($urandom_range(99)) < vprob[0]);
    valid_1 = (int'($urandom_range(99)) < vprob[1]);
    valid_2 = (int'($urandom_range(99)) < vprob[2]);
  endtask

  // Start a burst: fresh source data, grant mask applied before the next rising edge
  task automatic prep(input int owner, input logic [2:0] gmask);
    for (int k = 0; k < 3; k++) begin
      src_idx[k]   = 0;
      src_base[k]  = 8'($urandom);
      pulse_cyc[k] = -1;
    end
    cur_owner = owner;
    {gnt_2, gnt_1, gnt_0} = gmask;
    drive_valids();
    out_ready = rdy_bit(0);
    drive_data();
  endtask

  // Run cycles until the selected DUT returns idle, recording output beats and protocol observations
  task automatic run(input int max_cyc, input bit use1, output int cycles, output bit done);
    logic [2:0] hs;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       o_valid, o_busy;
    logic [7:0] o_data;
    logic [1:0] o_src;
    logic [2:0] o_rdy;
    obs_data.delete(); obs_src.delete(); obs_cyc.delete();
    bad_ready = 0; hold_bad = 0; owner_ready_cnt = 0;
    hs = 3'b000; prev_stall = 1'b0; prev_data = 8'h00;
    done = 1'b0; cycles = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (hs[k]) src_idx[k]++;
      gnt_0 = (pulse_cyc[0] == i);
      gnt_1 = (pulse_cyc[1] == i);
      gnt_2 = (pulse_cyc[2] == i);
      drive_valids();
      out_ready = rdy_bit(i);
      drive_data();
      @(negedge clk);
      cycles  = i;
      o_valid = use1 ? b1_out_valid : out_valid;
      o_busy  = use1 ? b1_busy : busy;
      o_data  = use1 ? b1_out_data : out_data;
      o_src   = use1 ? b1_out_src : out_src;
      o_rdy   = use1 ? {b1_ready_2, b1_ready_1, b1_ready_0} : {ready_2, ready_1, ready_0};
      if (!o_busy) begin
        done = 1'b1;
        break;
      end
      if (o_valid && out_ready) begin
        obs_data.push_back(o_data);
        obs_src.push_back(o_src);
        obs_cyc.push_back(i);
      end
      if (prev_stall && (o_data !== prev_data)) hold_bad++;
      prev_stall = o_valid && !out_ready;
      prev_data  = o_data;
      for (int k = 0; k < 3; k++) begin
        if (o_rdy[k] && (k != cur_owner)) bad_ready++;
        if (o_rdy[k] && (k == cur_owner)) owner_ready_cnt++;
      end
      hs = o_rdy & {valid_2, valid_1, valid_0};
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {gnt_2, gnt_1, gnt_0} = 3'b000;
    {valid_2, valid_1, valid_0} = 3'b111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    checks++; if (out_src !== 2'b11) begin failures++; $display("FAIL reset_out_src got=%0d want=3", out_src); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if ({ready_2, ready_1, ready_0} !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b want=000", {ready_2, ready_1, ready_0}); end
    checks++; if (gnt_err !== 1'b0) begin failures++; $display("FAIL reset_gnt_err got=%0b want=0", gnt_err); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc; bit done;
    use_pat = 1'b0; rprob = 100; vprob = '{0, 100, 0};
    prep(1, 3'b010);
    src_base[1] = 8'h10; drive_data();
    run(40, 1'b0, cyc, done);
    checks++; if (!done || cyc != 6) begin failures++; $display("FAIL basic_busy_cycles got=%0d done=%0b want=6", cyc, done); end
    checks++; if (obs_data.size() != 4) begin failures++; $display("FAIL basic_beat_count got=%0d want=4", obs_data.size()); end
    for (int j = 0; j < obs_data.size() && j < 4; j++) begin
      checks++;
      if (obs_data[j] !== 8'(8'h10 + j) || obs_src[j] !== 2'd1 || obs_cyc[j] != j + 2) begin
        failures++;
        $display("FAIL basic_beat%0d got data=%0h src=%0d cyc=%0d want data=%0h src=1 cyc=%0d", j, obs_data[j], obs_src[j], obs_cyc[j], 8'h10 + j, j + 2);
      end
    end
    checks++; if (owner_ready_cnt != 4) begin failures++; $display("FAIL basic_ready_cycles got=%0d want=4", owner_ready_cnt); end
  endtask

  task automatic test_ignore_grant();
    int cyc; bit done;
    use_pat = 1'b0; rprob = 100; vprob = '{100, 100, 100};
    prep(0, 3'b001);
    pulse_cyc[2] = 2;
    run(40, 1'b0, cyc, done);
    checks++; if (!done || obs_data.size() != 4) begin failures++; $display("FAIL ignore_beats got=%0d done=%0b want=4", obs_data.size(), done); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL ignore_nonowner_ready got=%0d want=0", bad_ready); end
    for (int j = 0; j < obs_data.size(); j++) begin
      checks++;
      if (obs_src[j] !== 2'd0 || obs_data[j] !== 8'(src_base[0] + 8'(j))) begin
        failures++; $display("FAIL ignore_beat%0d got src=%0d data=%0h want src=0 data=%0h", j, obs_src[j], obs_data[j], 8'(src_base[0] + 8'(j)));
      end
    end
    checks++; if (gnt_err !== exp_err) begin failures++; $display("FAIL ignore_gnt_err got=%0b want=%0b", gnt_err, exp_err); end
    prep(2, 3'b100);
    run(40, 1'b0, cyc, done);
    checks++; if (!done || obs_data.size() != 4) begin failures++; $display("FAIL regrant2_beats got=%0d want=4", obs_data.size()); end
    for (int j = 0; j < obs_data.size(); j++) begin
      checks++;
      if (obs_src[j] !== 2'd2 || obs_data[j] !== 8'(src_base[2] + 8'(j))) begin
        failures++; $display("FAIL regrant2_beat%0d got src=%0d data=%0h want src=2 data=%0h", j, obs_src[j], obs_data[j], 8'(src_base[2] + 8'(j)));
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc; bit done;
    use_pat = 1'b1; rdy_pat = ~32'h0000_001C; vprob = '{100, 0, 0};
    prep(0, 3'b001);
    run(40, 1'b0, cyc, done);
    use_pat = 1'b0;
    checks++; if (!done || cyc != 9) begin failures++; $display("FAIL bp_cycles got=%0d done=%0b want=9", cyc, done); end
    checks++; if (obs_data.size() != 4) begin failures++; $display("FAIL bp_beat_count got=%0d want=4", obs_data.size()); end
    for (int j = 0; j < obs_data.size(); j++) begin
      checks++;
      if (obs_data[j] !== 8'(src_base[0] + 8'(j))) begin
        failures++; $display("FAIL bp_beat%0d got=%0h want=%0h", j, obs_data[j], 8'(src_base[0] + 8'(j)));
      end
    end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL bp_data_hold got=%0d changes want=0", hold_bad); end
    checks++; if (owner_ready_cnt != 4) begin failures++; $display("FAIL bp_ready_cycles got=%0d want=4", owner_ready_cnt); end
  endtask

  task automatic test_multi_grant();
    int cyc; bit done;
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    use_pat = 1'b0; rprob = 100; vprob = '{100, 100, 100};
    prep(0, 3'b101);
    run(40, 1'b0, cyc, done);
    checks++; if (!done || obs_data.size() != 4) begin failures++; $display("FAIL multi_beats got=%0d want=4", obs_data.size()); end
    checks++; if (obs_data.size() > 0 && obs_src[0] !== 2'd0) begin failures++; $display("FAIL multi_owner got=%0d want=0", obs_src[0]); end
    checks++; if (bad_ready != 0) begin failures++; $display("FAIL multi_nonowner_ready got=%0d want=0", bad_ready); end
    checks++; if (gnt_err !== exp_err) begin failures++; $display("FAIL multi_gnt_err got=%0b want=%0b", gnt_err, exp_err); end
  endtask

  task automatic test_random();
    int cyc; bit done; int k;
    use_pat = 1'b0;
    for (int b = 0; b < 8; b++) begin
      k = int'($urandom_range(2));
      for (int q = 0; q < 3; q++) vprob[q] = int'($urandom_range(100, 30));
      rprob = int'($urandom_range(100, 30));
      prep(k, 3'(1 << k));
      run(300, 1'b0, cyc, done);
      checks++; if (!done || obs_data.size() != 4) begin failures++; $display("FAIL rand%0d_beats got=%0d done=%0b want=4", b, obs_data.size(), done); end
      checks++; if (bad_ready != 0 || hold_bad != 0) begin failures++; $display("FAIL rand%0d_protocol got bad_ready=%0d hold=%0d want 0", b, bad_ready, hold_bad); end
      for (int j = 0; j < obs_data.size(); j++) begin
        checks++;
        if (obs_src[j] !== 2'(k) || obs_data[j] !== 8'(src_base[k] + 8'(j))) begin
          failures++; $display("FAIL rand%0d_beat%0d got src=%0d data=%0h want src=%0d data=%0h", b, j, obs_src[j], obs_data[j], k, 8'(src_base[k] + 8'(j)));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit done;
    use_pat = 1'b0; rprob = 100; vprob = '{100, 100, 100};
    for (int b = 0; b < 3; b++) begin
      prep(b, 3'(1 << b));
      run(40, 1'b0, cyc, done);
      checks++; if (!done || cyc != 6 || obs_data.size() != 4) begin failures++; $display("FAIL b2b%0d got cycles=%0d beats=%0d want cycles=6 beats=4", b, cyc, obs_data.size()); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc; bit done;
    use_pat = 1'b0; rprob = 100; vprob = '{100, 100, 100};
    prep(0, 3'b001);
    run(3, 1'b0, cyc, done);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_state got busy=%0b out_valid=%0b want 0 0", busy, out_valid); end
    checks++; if (out_src !== 2'b11 || out_data !== 8'h00) begin failures++; $display("FAIL midrst_outputs got src=%0d data=%0h want 3 0", out_src, out_data); end
    checks++; if ({ready_2, ready_1, ready_0} !== 3'b000) begin failures++; $display("FAIL midrst_ready got=%b want=000", {ready_2, ready_1, ready_0}); end
    {gnt_2, gnt_1, gnt_0} = 3'b000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    prep(1, 3'b010);
    run(40, 1'b0, cyc, done);
    checks++; if (!done || obs_data.size() != 4 || obs_data[0] !== src_base[1] || obs_src[0] !== 2'd1) begin
      failures++; $display("FAIL midrst_resume got beats=%0d done=%0b want 4 beats from src 1", obs_data.size(), done);
    end
  endtask

  task automatic test_burst_len1();
    int cyc; bit done;
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    use_pat = 1'b0; rprob = 100; vprob = '{100, 100, 100};
    for (int k = 0; k < 3; k++) begin
      prep(k, 3'(1 << k));
      run(20, 1'b1, cyc, done);
      checks++; if (!done || cyc != 3) begin failures++; $display("FAIL bl1_%0d_cycles got=%0d done=%0b want=3", k, cyc, done); end
      checks++;
      if (obs_data.size() != 1 || obs_src[0] !== 2'(k) || obs_data[0] !== src_base[k]) begin
        failures++; $display("FAIL bl1_%0d_beat got count=%0d want one beat src=%0d data=%0h", k, obs_data.size(), k, src_base[k]);
      end
      checks++; if (bad_ready != 0) begin failures++; $display("FAIL bl1_%0d_nonowner_ready got=%0d want=0", k, bad_ready); end
    end
  endtask

  initial begin
`ifdef GRANT_BUS_MUX_GNT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b0;
    {gnt_2, gnt_1, gnt_0} = 3'b000;
    {valid_2, valid_1, valid_0} = 3'b000;
    data_0 = '0; data_1 = '0; data_2 = '0;
    out_ready = 1'b0;
    use_pat = 1'b0; rdy_pat = '1; rprob = 100;
    cur_owner = -1;
    for (int k = 0; k < 3; k++) begin
      src_base[k] = 8'h00; src_idx[k] = 0; vprob[k] = 100; pulse_cyc[k] = -1;
    end
    test_reset();
    @(negedge clk);
    test_basic();
    test_ignore_grant();
    test_backpressure();
    test_multi_grant();
    test_random();
    test_back_to_back();
    test_reset_mid_burst();
    test_burst_len1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
